// File: rtl/demux_stream_router_if.sv
// Stream bundle between one producer, the router, and N_OUT consumers.
// Handshake: a beat moves on a channel only in a cycle where that channel's valid and ready are both 1.
interface demux_stream_router_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [CNT_W-1:0]       drop_cnt;

    // Router side
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );

    // Producer/consumer side
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/demux_stream_router.sv
// Registered 1:N stream demux with unicast, all-or-nothing broadcast and a saturating
// counter for beats whose select names no channel.
module demux_stream_router #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_stream_router_if.slave bus
);
    logic [N_OUT-1:0][WIDTH-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]            out_valid_q, out_valid_d;
    logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0] onehot;
    logic [N_OUT-1:0] mask;
    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic             in_ready;
    logic             accept;

    always_comb begin
        onehot = '0;
        // An out-of-range select matches no channel, leaving the mask empty.
        for (int k = 0; k < N_OUT; k++) begin
            onehot[k] = (int'(bus.in_sel) == k);
        end
        mask     = bus.in_bcast ? {N_OUT{1'b1}} : onehot;
        free     = ~out_valid_q | bus.out_ready;
        in_ready = &(free | ~mask);
        accept   = bus.in_valid & in_ready;
        load     = accept ? mask : '0;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_cnt_d  = drop_cnt_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (load[k]) begin
                out_data_d[k]  = bus.in_data;
                out_valid_d[k] = 1'b1;
            end else if (bus.out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
        if (accept && (mask == '0) && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: a 4-channel instance checked every cycle against a slot
// model and per-channel ordering scoreboard, plus a 3-channel instance for drop counting.
module tb_demux_stream_router;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    demux_stream_router_if #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) bus4 ();
    demux_stream_router_if #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) bus3 ();

    demux_stream_router #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    demux_stream_router #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model + scoreboard ----------------
    // Each channel is a one-beat mailbox: a beat lands when every addressed mailbox is
    // empty or being emptied this cycle; a consumer taking the beat empties it.
    logic [3:0] m_valid;
    logic [7:0] m_data [4];
    int         m_drop;
    bit         model_ok = 1'b0;
    logic [7:0] exp_q [4][$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_sel;
    logic       prev_bcast;

    always @(negedge clk) begin : cmp_proc
        logic [3:0] hit;
        logic       exp_rdy;
        logic       acc;
        for (int k = 0; k < 4; k++) hit[k] = bus4.in_bcast || (int'(bus4.in_sel) == k);
        exp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (hit[k] && m_valid[k] && !bus4.out_ready[k]) exp_rdy = 1'b0;
        end
        if (model_ok) begin
            check("in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
            check("out_valid", 32'(bus4.out_valid), 32'(m_valid));
            for (int k = 0; k < 4; k++) check("out_data", 32'(bus4.out_data[k*8 +: 8]), 32'(m_data[k]));
            check("drop_cnt", 32'(bus4.drop_cnt), 32'(m_drop));
            for (int k = 0; k < 4; k++) begin
                if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                    if (exp_q[k].size() == 0) check("sb_depth", 32'(exp_q[k].size()), 32'd1);
                    else check("sb_order", 32'(bus4.out_data[k*8 +: 8]), 32'(exp_q[k].pop_front()));
                end
            end
            if (prev_stall && !rst) begin
                check("producer_hold", {14'd0, bus4.in_data, bus4.in_sel, bus4.in_bcast},
                      {14'd0, prev_data, prev_sel, prev_bcast});
            end
        end
        if (rst) begin
            m_valid  = '0;
            m_drop   = 0;
            for (int k = 0; k < 4; k++) begin
                m_data[k] = '0;
                exp_q[k].delete();
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = bus4.in_valid && exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (acc && hit[k]) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = bus4.in_data;
                    exp_q[k].push_back(bus4.in_data);
                end else if (m_valid[k] && bus4.out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        prev_stall = model_ok && !rst && bus4.in_valid && !exp_rdy;
        prev_data  = bus4.in_data;
        prev_sel   = bus4.in_sel;
        prev_bcast = bus4.in_bcast;
    end

    // ---------------- driver tasks ----------------
    task automatic drive4(input logic v, input logic [1:0] sel, input logic bc,
                          input logic [7:0] d, input logic [3:0] rdy);
        bus4.in_valid  = v;
        bus4.in_sel    = sel;
        bus4.in_bcast  = bc;
        bus4.in_data   = d;
        bus4.out_ready = rdy;
    endtask

    task automatic random_traffic(input int cycles, input int rst_at);
        bit pending = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                bus4.in_data  = 8'($urandom_range(0, 255));
                bus4.in_sel   = 2'($urandom_range(0, 3));
                bus4.in_bcast = ($urandom_range(0, 7) == 0);
                bus4.in_valid = 1'b1;
                pending = 1'b1;
            end
            bus4.out_ready = 4'($urandom_range(0, 15));
            rst = (c == rst_at);
            @(negedge clk);
            if (c == rst_at + 1) check("rst_mid_valid", 32'(bus4.out_valid), 32'd0);
            if (rst || (bus4.in_valid && bus4.in_ready)) pending = 1'b0;
            tick();
            if (!pending) bus4.in_valid = 1'b0;
        end
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        drive4(1'b1, 2'd0, 1'b0, 8'h77, 4'h0);
        bus3.in_valid = 1'b0; bus3.in_sel = 2'd0; bus3.in_bcast = 1'b0;
        bus3.in_data = 8'h00; bus3.out_ready = 3'b000;

        // 1: reset with a beat offered
        tick(); tick();
        @(negedge clk);
        check("rst_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_data", bus4.out_data, 32'd0);
        check("rst_drop", 32'(bus4.drop_cnt), 32'd0);
        check("rst_valid3", 32'(bus3.out_valid), 32'd0);
        tick();
        rst = 1'b0;

        // 2: unicast to channel 2
        drive4(1'b1, 2'd2, 1'b0, 8'hA5, 4'hF);
        @(negedge clk);
        check("uni_ready", 32'(bus4.in_ready), 32'd1);
        tick();
        check("model_pin_uni", 32'(m_valid), 32'h4);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("uni_valid", 32'(bus4.out_valid), 32'h4);
        check("uni_data", 32'(bus4.out_data[2*8 +: 8]), 32'hA5);
        tick();

        // 3: backpressure on channel 1
        drive4(1'b1, 2'd1, 1'b0, 8'h11, 4'b1101);
        tick();
        drive4(1'b1, 2'd1, 1'b0, 8'h5A, 4'b1101);
        @(negedge clk);
        check("bp_ready_lo", 32'(bus4.in_ready), 32'd0);
        check("bp_hold_data", 32'(bus4.out_data[1*8 +: 8]), 32'h11);
        tick();
        @(negedge clk);
        check("bp_hold_data2", 32'(bus4.out_data[1*8 +: 8]), 32'h11);
        tick();
        bus4.out_ready = 4'hF;
        @(negedge clk);
        check("bp_ready_hi", 32'(bus4.in_ready), 32'd1);
        tick();
        drive4(1'b0, 2'd1, 1'b0, 8'h5A, 4'b1101);
        @(negedge clk);
        check("bp_valid_kept", 32'(bus4.out_valid[1]), 32'd1);
        check("bp_new_data", 32'(bus4.out_data[1*8 +: 8]), 32'h5A);
        tick();

        // 4: broadcast blocked by a stalled full channel 3
        drive4(1'b1, 2'd3, 1'b0, 8'hC3, 4'b0111);
        tick();
        drive4(1'b1, 2'd0, 1'b1, 8'h3C, 4'b0111);
        @(negedge clk);
        check("bc_ready_lo", 32'(bus4.in_ready), 32'd0);
        check("bc_valid_blk", 32'(bus4.out_valid), 32'h8);
        tick();
        @(negedge clk);
        check("bc_no_partial", 32'(bus4.out_valid), 32'h8);
        check("bc_ch0_untouched", 32'(bus4.out_data[0 +: 8]), 32'h00);
        tick();
        bus4.out_ready = 4'hF;
        @(negedge clk);
        check("bc_ready_hi", 32'(bus4.in_ready), 32'd1);
        tick();
        drive4(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
        @(negedge clk);
        check("bc_valid_all", 32'(bus4.out_valid), 32'hF);
        check("bc_data_all", bus4.out_data, 32'h3C3C3C3C);
        tick();
        bus4.out_ready = 4'hF;
        tick(); tick();

        // 5: out-of-range select on the 3-channel router
        bus3.in_sel = 2'd3; bus3.in_data = 8'h99; bus3.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("drop_ready", 32'(bus3.in_ready), 32'd1);
            check("drop_no_valid", 32'(bus3.out_valid), 32'd0);
            check("drop_count", 32'(bus3.drop_cnt), (i > 255) ? 32'd255 : 32'(i));
            tick();
            bus3.in_data = 8'(i);
        end
        bus3.in_valid = 1'b0;
        @(negedge clk);
        check("drop_saturated", 32'(bus3.drop_cnt), 32'hFF);
        tick();

        // 6: random traffic with a one-cycle reset in the middle
        random_traffic(400, 200);
        drive4(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        tick(); tick(); tick();
        @(negedge clk);
        check("end_valid", 32'(bus4.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) check("end_sb_empty", 32'(exp_q[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
